// File: rtl/dcache_ctrl_pkg.sv
// Shared op codes, FSM encoding and access-classification helpers for the
// data-cache access controller.
package dcache_ctrl_pkg;

   localparam logic [3:0] OP_IDLE = 4'b0000;
   localparam logic [3:0] OP_LB   = 4'b1000;
   localparam logic [3:0] OP_LH   = 4'b1001;
   localparam logic [3:0] OP_LW   = 4'b1010;
   localparam logic [3:0] OP_SB   = 4'b1011;
   localparam logic [3:0] OP_LBU  = 4'b1100;
   localparam logic [3:0] OP_LHU  = 4'b1101;
   localparam logic [3:0] OP_SH   = 4'b1110;
   localparam logic [3:0] OP_SW   = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_SPLIT  = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   function automatic logic is_load(input logic [3:0] op);
      return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
             (op == OP_LBU) || (op == OP_LHU);
   endfunction

   function automatic logic is_half(input logic [3:0] op);
      return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
   endfunction

   function automatic logic is_word(input logic [3:0] op);
      return (op == OP_LW) || (op == OP_SW);
   endfunction

   function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
      return (is_half(op) && a[0]) || (is_word(op) && (a != 2'b00));
   endfunction

   // Number of byte beats a split access needs.
   function automatic logic [2:0] nbeats(input logic [3:0] op);
      if (is_word(op)) return 3'd4;
      if (is_half(op)) return 3'd2;
      return 3'd1;
   endfunction

endpackage

// File: rtl/dcache_load_extend.sv
// Sign/zero extension of raw load data according to the load op.
// Store ops and idle produce zero.
module dcache_load_extend
   import dcache_ctrl_pkg::*;
(
   input  logic [3:0]  op_i,
   input  logic [31:0] raw_i,
   output logic [31:0] data_o
);

   always_comb begin
      data_o = 32'h0;
      case (op_i)
         OP_LB:   data_o = {{24{raw_i[7]}}, raw_i[7:0]};
         OP_LH:   data_o = {{16{raw_i[15]}}, raw_i[15:0]};
         OP_LW:   data_o = raw_i;
         OP_LBU:  data_o = {24'h0, raw_i[7:0]};
         OP_LHU:  data_o = {16'h0, raw_i[15:0]};
         default: data_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/dcache_access_ctrl.sv
// Sequencer between MEM stage and data cache: one request at a time,
// misaligned halfword/word accesses split into byte beats or rejected.
module dcache_access_ctrl
   import dcache_ctrl_pkg::*;
#(
   parameter bit SPLIT_EN = 1'b1,
   parameter int ADDR_W   = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [3:0]        req_op_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   output logic              rsp_valid_o,
   output logic [31:0]       rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              busy_o,
   output logic [ADDR_W-1:0] dc_addr_o,
   output logic [31:0]       dc_wdata_o,
   output logic [3:0]        dc_sel_o,
   input  logic [31:0]       dc_rdata_i,
   input  logic              dc_busy_i
);

   typedef struct packed {
      logic [3:0]        op;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
   } req_t;

   state_e      state_q, state_d;
   req_t        req_q;
   logic [1:0]  beat_q;
   logic        err_q;
   logic        busy_q;
   logic [31:0] raw_q;
   logic [31:0] ext_data;
   logic        hs, mis, last_beat;

   assign hs        = (state_q == ST_IDLE) && req_valid_i && req_op_i[3];
   assign mis       = is_misaligned(req_op_i, req_addr_i[1:0]);
   assign last_beat = ({1'b0, beat_q} == (nbeats(req_q.op) - 3'd1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (hs) begin
               if (!mis)          state_d = ST_ACCESS;
               else if (SPLIT_EN) state_d = ST_SPLIT;
               else               state_d = ST_RESP;
            end
         end
         ST_ACCESS: if (!dc_busy_i) state_d = ST_RESP;
         ST_SPLIT:  if (!dc_busy_i && last_beat) state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // raw_q doubles as the aligned capture and the split assembly register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         req_q  <= '0;
         beat_q <= 2'd0;
         err_q  <= 1'b0;
         busy_q <= 1'b0;
         raw_q  <= 32'h0;
      end else begin
         busy_q <= (state_d != ST_IDLE);
         case (state_q)
            ST_IDLE: begin
               if (hs) begin
                  req_q  <= '{op: req_op_i, addr: req_addr_i, wdata: req_wdata_i};
                  beat_q <= 2'd0;
                  raw_q  <= 32'h0;
                  err_q  <= mis && !SPLIT_EN;
               end
            end
            ST_ACCESS: begin
               if (!dc_busy_i && is_load(req_q.op)) raw_q <= dc_rdata_i;
            end
            ST_SPLIT: begin
               if (!dc_busy_i) begin
                  if (is_load(req_q.op)) raw_q[{beat_q, 3'b000} +: 8] <= dc_rdata_i[7:0];
                  beat_q <= beat_q + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   dcache_load_extend u_ext (
      .op_i   (req_q.op),
      .raw_i  (raw_q),
      .data_o (ext_data)
   );

   always_comb begin
      req_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      rsp_rdata_o = 32'h0;
      rsp_err_o   = 1'b0;
      dc_sel_o    = OP_IDLE;
      dc_addr_o   = '0;
      dc_wdata_o  = 32'h0;
      case (state_q)
         ST_IDLE: req_ready_o = 1'b1;
         ST_ACCESS: begin
            dc_sel_o   = req_q.op;
            dc_addr_o  = req_q.addr;
            dc_wdata_o = req_q.wdata;
         end
         ST_SPLIT: begin
            dc_addr_o = req_q.addr + ADDR_W'(beat_q);
            if (is_load(req_q.op)) begin
               dc_sel_o = OP_LBU;
            end else begin
               dc_sel_o   = OP_SB;
               dc_wdata_o = {24'h0, req_q.wdata[{beat_q, 3'b000} +: 8]};
            end
         end
         ST_RESP: begin
            rsp_valid_o = 1'b1;
            rsp_err_o   = err_q;
            rsp_rdata_o = err_q ? 32'h0 : ext_data;
         end
         default: ;
      endcase
   end

   assign busy_o = busy_q;

endmodule

// File: tb/tb_dcache_access_ctrl.sv
// Directed bench for dcache_access_ctrl with a small byte-addressed cache model.
module tb_dcache_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_op = 4'h0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid, rsp_err, busy;
   logic [31:0] rsp_rdata;
   logic [31:0] dc_addr, dc_wdata, dc_rdata;
   logic [3:0]  dc_sel;
   logic        dc_busy = 1'b0;

   logic        n_valid = 1'b0;
   logic [3:0]  n_op = 4'h0;
   logic [31:0] n_addr = 32'h0;
   logic        n_ready, n_rsp_valid, n_rsp_err, n_busy;
   logic [31:0] n_rsp_rdata, n_dc_addr, n_dc_wdata;
   logic [3:0]  n_dc_sel;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dcache_access_ctrl u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
      .busy_o(busy), .dc_addr_o(dc_addr), .dc_wdata_o(dc_wdata), .dc_sel_o(dc_sel),
      .dc_rdata_i(dc_rdata), .dc_busy_i(dc_busy)
   );

   dcache_access_ctrl #(.SPLIT_EN(1'b0), .ADDR_W(32)) u_nosplit (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(n_valid), .req_ready_o(n_ready), .req_op_i(n_op),
      .req_addr_i(n_addr), .req_wdata_i(32'h0),
      .rsp_valid_o(n_rsp_valid), .rsp_rdata_o(n_rsp_rdata), .rsp_err_o(n_rsp_err),
      .busy_o(n_busy), .dc_addr_o(n_dc_addr), .dc_wdata_o(n_dc_wdata), .dc_sel_o(n_dc_sel),
      .dc_rdata_i(32'h0), .dc_busy_i(1'b0)
   );

   // Cache model: 1 KiB aliased byte store, combinational read, write on clock.
   logic [7:0]  mem [0:1023];
   logic        pl_we = 1'b0;
   logic [31:0] pl_a = 32'h0;
   logic [31:0] pl_d = 32'h0;
   logic [9:0]  ra;

   assign ra = dc_addr[9:0];

   always_comb begin
      dc_rdata = 32'h0;
      case (dc_sel)
         4'b1000, 4'b1100: dc_rdata = {24'h0, mem[ra]};
         4'b1001, 4'b1101: dc_rdata = {16'h0, mem[ra + 10'd1], mem[ra]};
         4'b1010:          dc_rdata = {mem[ra + 10'd3], mem[ra + 10'd2], mem[ra + 10'd1], mem[ra]};
         default:          dc_rdata = 32'h0;
      endcase
   end

   always @(posedge clk) begin
      int nb;
      nb = (dc_sel == 4'b1011) ? 1 : (dc_sel == 4'b1110) ? 2 : (dc_sel == 4'b1111) ? 4 : 0;
      if (pl_we) begin
         for (int i = 0; i < 4; i++) mem[pl_a[9:0] + 10'(i)] <= pl_d[8*i +: 8];
      end else if (!dc_busy) begin
         for (int i = 0; i < nb; i++) mem[dc_addr[9:0] + 10'(i)] <= dc_wdata[8*i +: 8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic pl(input logic [31:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      pl_we = 1'b1; pl_a = a; pl_d = d;
      @(posedge clk); #1;
      pl_we = 1'b0;
   endtask

   // Per-cycle trace of a request; index k = cycles after the handshake cycle.
   logic [3:0]  tr_sel  [0:31];
   logic [31:0] tr_addr [0:31];
   logic [31:0] tr_wd   [0:31];
   logic        tr_busy [0:31];
   int          lat;
   logic [31:0] r_data;
   logic        r_err, rdy0, post_rdy, post_rsp;

   task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] bmask);
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd; dc_busy = 1'b0;
      @(negedge clk);
      rdy0 = req_ready;
      lat = 0; r_data = 32'h0; r_err = 1'b0;
      for (int k = 1; k < 32 && lat == 0; k++) begin
         @(posedge clk); #1;
         req_valid = 1'b0;
         dc_busy = bmask[k];
         @(negedge clk);
         tr_sel[k] = dc_sel; tr_addr[k] = dc_addr; tr_wd[k] = dc_wdata; tr_busy[k] = busy;
         if (rsp_valid) begin
            lat = k; r_data = rsp_rdata; r_err = rsp_err;
         end
      end
      @(posedge clk); #1;
      dc_busy = 1'b0;
      @(negedge clk);
      post_rdy = req_ready; post_rsp = rsp_valid;
   endtask

   initial begin
      logic seen;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", req_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_sel", dc_sel, 4'h0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      rst_n = 1'b1;

      // Aligned LW
      pl(32'h100, 32'hDEADBEEF);
      run(4'b1010, 32'h100, 32'h0, 32'h0);
      chk("lw_ready_hs", rdy0, 1'b1);
      chk("lw_lat", lat, 2);
      chk("lw_sel1", tr_sel[1], 4'b1010);
      chk("lw_addr1", tr_addr[1], 32'h100);
      chk("lw_busy1", tr_busy[1], 1'b1);
      chk("lw_busy2", tr_busy[2], 1'b1);
      chk("lw_rdata", r_data, 32'hDEADBEEF);
      chk("lw_err", r_err, 1'b0);
      chk("lw_rsp_pulse", post_rsp, 1'b0);
      chk("lw_ready_after", post_rdy, 1'b1);

      // Byte 0x203 = 0x80, byte 0x204 = 0xFF
      pl(32'h200, 32'h80000000);
      pl(32'h204, 32'h000000FF);
      run(4'b1000, 32'h203, 32'h0, 32'h0);
      chk("lb_lat", lat, 2);
      chk("lb_rdata", r_data, 32'hFFFFFF80);
      run(4'b1100, 32'h203, 32'h0, 32'h0);
      chk("lbu_rdata", r_data, 32'h00000080);

      run(4'b1001, 32'h203, 32'h0, 32'h0);
      chk("lh_lat", lat, 3);
      chk("lh_sel1", tr_sel[1], 4'b1100);
      chk("lh_addr1", tr_addr[1], 32'h203);
      chk("lh_sel2", tr_sel[2], 4'b1100);
      chk("lh_addr2", tr_addr[2], 32'h204);
      chk("lh_rdata", r_data, 32'hFFFFFF80);
      run(4'b1101, 32'h203, 32'h0, 32'h0);
      chk("lhu_rdata", r_data, 32'h0000FF80);

      // Split word store
      pl(32'h300, 32'h0);
      pl(32'h304, 32'h0);
      run(4'b1111, 32'h301, 32'h11223344, 32'h0);
      chk("sw_lat", lat, 5);
      chk("sw_rdata", r_data, 32'h0);
      for (int k = 1; k <= 4; k++) begin
         chk("sw_sel", tr_sel[k], 4'b1011);
         chk("sw_addr", tr_addr[k], 32'h300 + 32'(k));
      end
      chk("sw_wd1", tr_wd[1][7:0], 8'h44);
      chk("sw_wd2", tr_wd[2][7:0], 8'h33);
      chk("sw_wd3", tr_wd[3][7:0], 8'h22);
      chk("sw_wd4", tr_wd[4][7:0], 8'h11);
      run(4'b1010, 32'h300, 32'h0, 32'h0);
      chk("rb_300", r_data, 32'h22334400);
      run(4'b1010, 32'h304, 32'h0, 32'h0);
      chk("rb_304", r_data, 32'h00000011);

      // Request without access enable is dropped
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = 4'b0011; req_addr = 32'h100;
      @(negedge clk);
      chk("noen_ready", req_ready, 1'b1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("noen_busy", busy, 1'b0);
      chk("noen_rsp", rsp_valid, 1'b0);
      chk("noen_sel", dc_sel, 4'h0);

      // Rejected misaligned access on the non-splitting instance
      @(posedge clk); #1;
      n_valid = 1'b1; n_op = 4'b1010; n_addr = 32'h002;
      @(negedge clk);
      chk("rej_sel0", n_dc_sel, 4'h0);
      @(posedge clk); #1;
      n_valid = 1'b0;
      @(negedge clk);
      chk("rej_valid", n_rsp_valid, 1'b1);
      chk("rej_err", n_rsp_err, 1'b1);
      chk("rej_rdata", n_rsp_rdata, 32'h0);
      chk("rej_sel1", n_dc_sel, 4'h0);
      @(negedge clk);
      chk("rej_pulse", n_rsp_valid, 1'b0);
      chk("rej_ready", n_ready, 1'b1);

      // Cache stall during aligned access (cycles 1..3)
      run(4'b1010, 32'h100, 32'h0, 32'h0000000E);
      chk("stall_lat", lat, 5);
      for (int k = 1; k <= 4; k++) begin
         chk("stall_sel", tr_sel[k], 4'b1010);
         chk("stall_addr", tr_addr[k], 32'h100);
      end
      chk("stall_rdata", r_data, 32'hDEADBEEF);

      // Cache stall on split beat 1 (cycles 2..4)
      run(4'b1111, 32'h301, 32'h11223344, 32'h0000001C);
      chk("sstall_lat", lat, 8);
      for (int k = 2; k <= 5; k++) begin
         chk("sstall_sel", tr_sel[k], 4'b1011);
         chk("sstall_addr", tr_addr[k], 32'h302);
         chk("sstall_wd", tr_wd[k][7:0], 8'h33);
      end
      chk("sstall_addr6", tr_addr[6], 32'h303);

      // Reset during beat 2 of a split word store
      pl(32'h340, 32'h0);
      pl(32'h344, 32'h0);
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = 4'b1111; req_addr = 32'h341; req_wdata = 32'h55667788;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("ra_sel_pre", dc_sel, 4'b1011);
      chk("ra_addr_pre", dc_addr, 32'h343);
      rst_n = 1'b0;
      #1;
      chk("ra_sel", dc_sel, 4'h0);
      chk("ra_ready", req_ready, 1'b1);
      chk("ra_busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      chk("ra_no_rsp", seen, 1'b0);
      run(4'b1010, 32'h340, 32'h0, 32'h0);
      chk("ra_mem", r_data, 32'h00778800);

      // Address wrap on split word load
      pl(32'hFFFFFFFC, 32'hBBAA0000);
      pl(32'h00000000, 32'h0000DDCC);
      run(4'b1010, 32'hFFFFFFFE, 32'h0, 32'h0);
      chk("wrap_lat", lat, 5);
      chk("wrap_a1", tr_addr[1], 32'hFFFFFFFE);
      chk("wrap_a2", tr_addr[2], 32'hFFFFFFFF);
      chk("wrap_a3", tr_addr[3], 32'h00000000);
      chk("wrap_a4", tr_addr[4], 32'h00000001);
      chk("wrap_rdata", r_data, 32'hDDCCBBAA);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dcache_access_ctrl.md
Name: dcache_access_ctrl

Overview:
- Sequencer between the pipeline MEM stage and data_cache.
- Accepts one load/store request at a time using a valid/ready handshake and drives the cache's address, write-data and 4-bit select interface.
- Splits misaligned halfword/word accesses into byte beats, then returns registered, extended load data with a one-cycle response pulse.
- Drives busy_o so the pipeline stalls while a request is in flight.

Parameters:
- SPLIT_EN, 1: 1 = split misaligned accesses into byte beats; 0 = reject them with rsp_err_o, no cache access.
- ADDR_W, 32: address width; byte-address increments wrap modulo 2^ADDR_W.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  controller can accept a request.
- req_op_i  in  4  op code. bit3 = access enable. Loads: 1000 LB, 1001 LH, 1010 LW, 1100 LBU, 1101 LHU. Stores: 1011 SB, 1110 SH, 1111 SW.
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  32  store data, low-aligned.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  misaligned access rejected; valid with rsp_valid_o.
- busy_o  out  1  stall to pipeline.
- dc_addr_o  out  ADDR_W  cache address.
- dc_wdata_o  out  32  cache write data.
- dc_sel_o  out  4  cache select, same encoding as req_op_i; 0000 = idle.
- dc_rdata_i  in  32  cache read data, combinational in the same cycle.
- dc_busy_i  in  1  cache stall; the current beat is held while high.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; beat counter 0; all outputs 0 except req_ready_o = 1.
- Reset mid-operation: abort immediately and drive dc_sel_o = 0000. Bytes already written stay written. No response is issued.
- States: IDLE, ACCESS, SPLIT, RESP.
- IDLE:
  - req_ready_o = 1, busy_o = 0, dc_sel_o = 0000.
  - A handshake is req_valid_i & req_op_i[3]. On a handshake, latch op, addr and wdata.
  - req_valid_i with op[3] = 0 is consumed silently: no response, stay in IDLE.
- Misalignment classification: half ops misaligned when addr[0] = 1; word ops misaligned when addr[1:0] != 00; byte ops never misaligned.
- IDLE transitions on a handshake:
  - Aligned -> ACCESS.
  - Misaligned with SPLIT_EN = 1 -> SPLIT, beat = 0, nbeats = 2 (half) or 4 (word).
  - Misaligned with SPLIT_EN = 0 -> RESP with rsp_err_o = 1 and no cache access.
- ACCESS:
  - dc_sel_o = latched op, dc_addr_o = latched addr, dc_wdata_o = latched wdata.
  - If dc_busy_i = 1, hold all outputs and stay.
  - Otherwise capture dc_rdata_i (loads only) and go to RESP.
- SPLIT:
  - dc_addr_o = addr + beat, wrapping modulo 2^ADDR_W.
  - Loads use dc_sel_o = 1100 (LBU). dc_rdata_i[7:0] is captured into assembly byte lane [beat].
  - Stores use dc_sel_o = 1011 (SB) with dc_wdata_o[7:0] = wdata byte [beat].
  - If dc_busy_i = 1, hold the beat.
  - Otherwise increment beat; after the last beat go to RESP.
- RESP:
  - rsp_valid_o = 1 for exactly one cycle, then return to IDLE.
  - Load data extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
  - Aligned path uses data captured from the cache; split path uses the assembly register.
  - Stores and errors return 0.
- req_ready_o = 1 only in IDLE. busy_o = (state != IDLE), registered.
- Latency with dc_busy_i = 0, handshake in cycle N:
  - Aligned access: cache access in N+1, rsp_valid_o in N+2.
  - Split halfword: rsp_valid_o in N+3. Split word: rsp_valid_o in N+5.
  - Rejected access: rsp_valid_o in N+1.
- Throughput: one request per (latency + 1) cycles, since req_ready_o is low in RESP.

Decomposition:
- Package dcache_ctrl_pkg holds:
  - op code localparams (OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, OP_IDLE);
  - the state encoding;
  - helper functions is_load(op), is_misaligned(op, addr[1:0]), nbeats(op).
- One combinational sub-module, dcache_load_extend: inputs op and 32-bit raw data, output extended data. It is shared by the aligned and split paths.

Test Plan:
- Aligned LW at 0x100, cache returns 0xDEADBEEF, dc_busy_i = 0 -> dc_sel_o = 1010 in N+1; rsp_valid_o in N+2 with rsp_rdata_o = 0xDEADBEEF; busy_o high in N+1 and N+2.
- LH at 0x203 with bytes 0x203 = 0x80 and 0x204 = 0xFF, SPLIT_EN = 1 -> two beats with dc_sel_o = 1100 at 0x203 then 0x204; rsp_rdata_o = 0xFFFFFF80. Same access as LHU -> 0x0000FF80.
- SW 0x11223344 at 0x301 -> four SB beats at 0x301..0x304 carrying bytes 44, 33, 22, 11; rsp_valid_o in N+5; a following aligned LW from 0x300 and LW from 0x304 read back the bytes in the expected lanes.
- SPLIT_EN = 0, LW at 0x002 -> dc_sel_o stays 0000; rsp_valid_o and rsp_err_o both high in N+1; rsp_rdata_o = 0.
- dc_busy_i held high for 3 cycles during ACCESS, then on split beat 1 -> addr, sel and wdata held stable throughout; response delayed by exactly the stall cycles.
- rst_ni asserted during split beat 2 of a word store -> dc_sel_o = 0000 immediately, state IDLE, no rsp_valid_o. Also: LW split at 0xFFFFFFFE wraps beats to 0xFFFFFFFF, 0x0, 0x1.
